// File: rtl/nts_dispatcher_frontend.sv
// ----------------------------------------------------------------------------
// nts_dispatcher_frontend
//
// Receive-side ping-pong frame buffer for the NTS dispatcher. MAC RX words are
// written into the write bank. A frame that ends good and is then processed is
// handed to the dispatch side, which owns the other bank. The dispatch side
// reads the frame word by word and releases the bank with a discard strobe.
//
// Optional feature macro: NTS_DISPATCHER_FRONTEND_DEBUG_COUNTERS_EN
//   When defined, the block adds saturating frame counters
//   o_dbg_frames_dispatched and o_dbg_frames_dropped.
//
// Ports:
//   i_clk, i_areset                 clock, asynchronous active-low reset
//   i_rx_data_valid/i_rx_data       RX word and its byte-valid mask
//   i_rx_bad_frame/i_rx_good_frame  frame end markers for the current word
//   i_process_frame                 hand the completed frame to the dispatch side
//   o_dispatch_packet_available     a frame is held for the dispatch side
//   i_dispatch_packet_read_discard  dispatch side is done; free its bank
//   o_dispatch_counter              address of the last word of the held frame
//   o_dispatch_data_valid           byte-valid mask of that last word
//   o_dispatch_fifo_empty           every word of the held frame has been read
//   i_dispatch_fifo_rd_en           read the next word
//   o_dispatch_fifo_rd_data         registered read data
// ----------------------------------------------------------------------------
module nts_dispatcher_frontend #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [7:0]            i_rx_data_valid,
  input  logic [63:0]           i_rx_data,
  input  logic                  i_rx_bad_frame,
  input  logic                  i_rx_good_frame,
  input  logic                  i_process_frame,
  output logic                  o_dispatch_packet_available,
  input  logic                  i_dispatch_packet_read_discard,
  output logic [ADDR_WIDTH-1:0] o_dispatch_counter,
  output logic [7:0]            o_dispatch_data_valid,
  output logic                  o_dispatch_fifo_empty,
  input  logic                  i_dispatch_fifo_rd_en,
  output logic [63:0]           o_dispatch_fifo_rd_data
`ifdef NTS_DISPATCHER_FRONTEND_DEBUG_COUNTERS_EN
  ,
  output logic [31:0]           o_dbg_frames_dispatched,
  output logic [31:0]           o_dbg_frames_dropped
`endif
);

  localparam int                    DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // Both banks in one array, addressed as {bank, word}.
  logic [63:0] mem [2*DEPTH];

  // Write side state
  logic                  wr_bank;      // bank owned by the write side
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  wr_wrap;      // the bank's last address has been written
  logic                  wr_ovf;       // a word arrived after the bank filled
  logic                  wr_complete;  // write bank holds a good, unread frame
  logic                  pending;      // complete frame waiting for handover
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [7:0]            last_valid;

  // Read side state; the read side owns the bank the write side does not
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic word, handover, ovf_now, end_bad, end_good, frame_end;
  logic accept_good, supersede, do_discard, do_read, wr_sel_bank;
  logic complete_n, pending_n;

  assign word        = |i_rx_data_valid;
  assign handover    = pending & ~o_dispatch_packet_available;
  assign ovf_now     = wr_ovf | wr_wrap;
  assign end_bad     = word & i_rx_bad_frame;
  assign end_good    = word & i_rx_good_frame & ~i_rx_bad_frame;
  assign frame_end   = end_bad | end_good;
  assign accept_good = end_good & ~ovf_now;
  // A new word while a complete frame waits in the write bank overwrites it,
  // unless that frame leaves for the read side on this very edge.
  assign supersede   = word & wr_complete & ~handover;
  assign do_discard  = i_dispatch_packet_read_discard & o_dispatch_packet_available;
  assign do_read     = i_dispatch_fifo_rd_en & ~o_dispatch_fifo_empty & ~do_discard;
  // On a handover edge the banks swap, so an incoming word lands in the freed bank.
  assign wr_sel_bank = handover ? ~wr_bank : wr_bank;
  assign rd_bank     = ~wr_bank;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    complete_n = wr_complete;
    pending_n  = pending;
    if (handover || supersede) begin
      complete_n = 1'b0;
      pending_n  = 1'b0;
    end
    if (accept_good) complete_n = 1'b1;
    // A process strobe with nothing complete is ignored.
    if (i_process_frame && complete_n) pending_n = 1'b1;
  end

  // NOTE: the frame memory has no reset; its contents are only observed after
  // being written, and a reset on the array would stop it mapping to RAM.
  always_ff @(posedge i_clk) begin
    if (word) mem[{wr_sel_bank, wr_ptr}] <= i_rx_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      wr_bank     <= 1'b0;
      wr_ptr      <= '0;
      wr_wrap     <= 1'b0;
      wr_ovf      <= 1'b0;
      wr_complete <= 1'b0;
      pending     <= 1'b0;
      last_addr   <= '0;
      last_valid  <= '0;
    end else begin
      wr_complete <= complete_n;
      pending     <= pending_n;
      if (handover) wr_bank <= ~wr_bank;
      if (word) begin
        if (frame_end) begin
          wr_ptr  <= '0;
          wr_wrap <= 1'b0;
          wr_ovf  <= 1'b0;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LAST_ADDR) wr_wrap <= 1'b1;
          if (wr_wrap)             wr_ovf  <= 1'b1;
        end
      end
      if (accept_good) begin
        last_addr  <= wr_ptr;
        last_valid <= i_rx_data_valid;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      o_dispatch_packet_available <= 1'b0;
      o_dispatch_counter          <= '0;
      o_dispatch_data_valid       <= '0;
      o_dispatch_fifo_empty       <= 1'b1;
      o_dispatch_fifo_rd_data     <= '0;
      rd_ptr                      <= '0;
    end else if (handover) begin
      o_dispatch_packet_available <= 1'b1;
      o_dispatch_counter          <= last_addr;
      o_dispatch_data_valid       <= last_valid;
      o_dispatch_fifo_empty       <= 1'b0;
      rd_ptr                      <= '0;
    end else if (do_discard) begin
      o_dispatch_packet_available <= 1'b0;
      o_dispatch_counter          <= '0;
      o_dispatch_data_valid       <= '0;
      o_dispatch_fifo_empty       <= 1'b1;
    end else if (do_read) begin
      o_dispatch_fifo_rd_data <= mem[{rd_bank, rd_ptr}];
      rd_ptr                  <= rd_ptr + 1'b1;
      if (rd_ptr == o_dispatch_counter) o_dispatch_fifo_empty <= 1'b1;
    end
  end

`ifdef NTS_DISPATCHER_FRONTEND_DEBUG_COUNTERS_EN
  logic [1:0] drop_inc;

  // A superseding word can itself be a bad single-word frame: two drops at once.
  assign drop_inc = 2'(supersede) + 2'(frame_end & (end_bad | ovf_now));

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      o_dbg_frames_dispatched <= '0;
      o_dbg_frames_dropped    <= '0;
    end else begin
      if (handover && o_dbg_frames_dispatched != '1)
        o_dbg_frames_dispatched <= o_dbg_frames_dispatched + 1'b1;
      if (o_dbg_frames_dropped > 32'hFFFF_FFFF - 32'(drop_inc))
        o_dbg_frames_dropped <= '1;
      else
        o_dbg_frames_dropped <= o_dbg_frames_dropped + 32'(drop_inc);
    end
  end
`endif

endmodule

// File: tb/tb_nts_dispatcher_frontend.sv
// ----------------------------------------------------------------------------
// tb_nts_dispatcher_frontend
//
// Directed bench for nts_dispatcher_frontend with ADDR_WIDTH = 3. Inputs are
// driven and outputs checked 1 ns after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_nts_dispatcher_frontend;

  logic        i_clk = 1'b0;
  logic        i_areset;
  logic [7:0]  i_rx_data_valid;
  logic [63:0] i_rx_data;
  logic        i_rx_bad_frame;
  logic        i_rx_good_frame;
  logic        i_process_frame;
  logic        o_dispatch_packet_available;
  logic        i_dispatch_packet_read_discard;
  logic [2:0]  o_dispatch_counter;
  logic [7:0]  o_dispatch_data_valid;
  logic        o_dispatch_fifo_empty;
  logic        i_dispatch_fifo_rd_en;
  logic [63:0] o_dispatch_fifo_rd_data;
`ifdef NTS_DISPATCHER_FRONTEND_DEBUG_COUNTERS_EN
  logic [31:0] o_dbg_frames_dispatched;
  logic [31:0] o_dbg_frames_dropped;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  nts_dispatcher_frontend #(.ADDR_WIDTH(3)) dut (
    .i_clk                          (i_clk),
    .i_areset                       (i_areset),
    .i_rx_data_valid                (i_rx_data_valid),
    .i_rx_data                      (i_rx_data),
    .i_rx_bad_frame                 (i_rx_bad_frame),
    .i_rx_good_frame                (i_rx_good_frame),
    .i_process_frame                (i_process_frame),
    .o_dispatch_packet_available    (o_dispatch_packet_available),
    .i_dispatch_packet_read_discard (i_dispatch_packet_read_discard),
    .o_dispatch_counter             (o_dispatch_counter),
    .o_dispatch_data_valid          (o_dispatch_data_valid),
    .o_dispatch_fifo_empty          (o_dispatch_fifo_empty),
    .i_dispatch_fifo_rd_en          (i_dispatch_fifo_rd_en),
    .o_dispatch_fifo_rd_data        (o_dispatch_fifo_rd_data)
`ifdef NTS_DISPATCHER_FRONTEND_DEBUG_COUNTERS_EN
    ,
    .o_dbg_frames_dispatched        (o_dbg_frames_dispatched),
    .o_dbg_frames_dropped           (o_dbg_frames_dropped)
`endif
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One RX word; markers are cleared again after the edge.
  task automatic send_word(input logic [63:0] data, input logic [7:0] valid,
                           input logic good, input logic bad);
    i_rx_data       = data;
    i_rx_data_valid = valid;
    i_rx_good_frame = good;
    i_rx_bad_frame  = bad;
    step();
    i_rx_data_valid = '0;
    i_rx_good_frame = 1'b0;
    i_rx_bad_frame  = 1'b0;
  endtask

  task automatic pulse_process();
    i_process_frame = 1'b1;
    step();
    i_process_frame = 1'b0;
  endtask

  task automatic pulse_discard();
    i_dispatch_packet_read_discard = 1'b1;
    step();
    i_dispatch_packet_read_discard = 1'b0;
  endtask

  initial begin
    i_areset                       = 1'b0;
    i_rx_data_valid                = '0;
    i_rx_data                      = '0;
    i_rx_bad_frame                 = 1'b0;
    i_rx_good_frame                = 1'b0;
    i_process_frame                = 1'b0;
    i_dispatch_packet_read_discard = 1'b0;
    i_dispatch_fifo_rd_en          = 1'b0;

    // Reset state
    #12;
    check("rst_available", 64'(o_dispatch_packet_available), 64'd0);
    check("rst_counter",   64'(o_dispatch_counter),          64'd0);
    check("rst_dv",        64'(o_dispatch_data_valid),       64'd0);
    check("rst_empty",     64'(o_dispatch_fifo_empty),       64'd1);
    check("rst_rd_data",   o_dispatch_fifo_rd_data,          64'd0);
    i_areset = 1'b1;
    step();

    // Frame A: three words, good on the third
    send_word(64'h0102030405060708, 8'hFF, 1'b0, 1'b0);
    send_word(64'h0000000220202020, 8'hFF, 1'b0, 1'b0);
    send_word(64'h0000000330303030, 8'hFF, 1'b1, 1'b0);
    check("a_avail_before_process", 64'(o_dispatch_packet_available), 64'd0);
    pulse_process();
    check("a_avail_edge1", 64'(o_dispatch_packet_available), 64'd0);
    step();
    check("a_avail_edge2", 64'(o_dispatch_packet_available), 64'd1);
    check("a_counter",     64'(o_dispatch_counter),          64'd2);
    check("a_dv",          64'(o_dispatch_data_valid),       64'hFF);
    check("a_empty",       64'(o_dispatch_fifo_empty),       64'd0);

    // Read the three words back-to-back
    i_dispatch_fifo_rd_en = 1'b1;
    step();
    check("a_rd0",       o_dispatch_fifo_rd_data,     64'h0102030405060708);
    check("a_rd0_empty", 64'(o_dispatch_fifo_empty),  64'd0);
    step();
    check("a_rd1",       o_dispatch_fifo_rd_data,     64'h0000000220202020);
    check("a_rd1_empty", 64'(o_dispatch_fifo_empty),  64'd0);
    step();
    check("a_rd2",       o_dispatch_fifo_rd_data,     64'h0000000330303030);
    check("a_rd2_empty", 64'(o_dispatch_fifo_empty),  64'd1);
    // Reading while empty leaves the data untouched
    step();
    i_dispatch_fifo_rd_en = 1'b0;
    check("a_rd_empty_hold", o_dispatch_fifo_rd_data, 64'h0000000330303030);

    pulse_discard();
    check("a_discard_avail",   64'(o_dispatch_packet_available), 64'd0);
    check("a_discard_empty",   64'(o_dispatch_fifo_empty),       64'd1);
    check("a_discard_counter", 64'(o_dispatch_counter),          64'd0);
    check("a_discard_dv",      64'(o_dispatch_data_valid),       64'd0);
    // Discard with nothing held is ignored
    pulse_discard();
    check("idle_discard_avail", 64'(o_dispatch_packet_available), 64'd0);

    // Bad frame followed by process: nothing handed over
    send_word(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0, 1'b0);
    send_word(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b0, 1'b1);
    pulse_process();
    step();
    check("bad_avail", 64'(o_dispatch_packet_available), 64'd0);
    check("bad_empty", 64'(o_dispatch_fifo_empty),       64'd1);

    // Next good frame starts at address 0
    send_word(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0);
    send_word(64'h2222_2222_2222_2222, 8'h0F, 1'b1, 1'b0);
    pulse_process();
    step();
    check("b_avail",   64'(o_dispatch_packet_available), 64'd1);
    check("b_counter", 64'(o_dispatch_counter),          64'd1);
    check("b_dv",      64'(o_dispatch_data_valid),       64'h0F);
    // Read and discard in the same cycle: discard wins, data unchanged
    i_dispatch_fifo_rd_en = 1'b1;
    i_dispatch_packet_read_discard = 1'b1;
    step();
    i_dispatch_packet_read_discard = 1'b0;
    i_dispatch_fifo_rd_en = 1'b0;
    check("b_rd_vs_discard_avail", 64'(o_dispatch_packet_available), 64'd0);
    check("b_rd_vs_discard_data",  o_dispatch_fifo_rd_data, 64'h0000000330303030);

    // Frame B again, this time reading word 0
    send_word(64'h3333_3333_3333_3333, 8'hFF, 1'b0, 1'b0);
    send_word(64'h4444_4444_4444_4444, 8'h03, 1'b1, 1'b0);
    pulse_process();
    step();
    i_dispatch_fifo_rd_en = 1'b1;
    step();
    i_dispatch_fifo_rd_en = 1'b0;
    check("b2_rd0",    o_dispatch_fifo_rd_data,    64'h3333_3333_3333_3333);
    check("b2_dv",     64'(o_dispatch_data_valid), 64'h03);
    pulse_discard();

    // Nine-word frame overflows an eight-word bank and is dropped
    for (int i = 0; i < 9; i++)
      send_word(64'(i) | 64'h9900_0000_0000_0000, 8'hFF, (i == 8), 1'b0);
    pulse_process();
    step();
    check("ovf_avail", 64'(o_dispatch_packet_available), 64'd0);

    // Frame C held while frame D is processed
    send_word(64'hC0C0_C0C0_C0C0_C0C0, 8'hFF, 1'b0, 1'b0);
    send_word(64'hC1C1_C1C1_C1C1_C1C1, 8'hFF, 1'b1, 1'b0);
    pulse_process();
    step();
    check("c_avail",   64'(o_dispatch_packet_available), 64'd1);
    send_word(64'hD0D0_D0D0_D0D0_D0D0, 8'h0F, 1'b1, 1'b0);
    pulse_process();
    step();
    check("d_held_avail",   64'(o_dispatch_packet_available), 64'd1);
    check("d_held_counter", 64'(o_dispatch_counter),          64'd1);
    check("d_held_dv",      64'(o_dispatch_data_valid),       64'hFF);
    pulse_discard();
    check("d_freed_avail", 64'(o_dispatch_packet_available), 64'd0);
    step();
    check("d_avail",   64'(o_dispatch_packet_available), 64'd1);
    check("d_counter", 64'(o_dispatch_counter),          64'd0);
    check("d_dv",      64'(o_dispatch_data_valid),       64'h0F);
    check("d_empty",   64'(o_dispatch_fifo_empty),       64'd0);
    i_dispatch_fifo_rd_en = 1'b1;
    step();
    i_dispatch_fifo_rd_en = 1'b0;
    check("d_rd0",       o_dispatch_fifo_rd_data,    64'hD0D0_D0D0_D0D0_D0D0);
    check("d_rd0_empty", 64'(o_dispatch_fifo_empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nts_dispatcher_frontend.md
Name: nts_dispatcher_frontend

Overview:
Receive-side front buffer of the NTS dispatcher. It captures 64-bit Ethernet MAC RX words into one of two ping-pong frame banks. On a good frame plus a process decision, it hands the bank to the dispatch (read) side, which reads it word by word and then releases it with a read/discard strobe. It sits between the MAC RX interface and the dispatcher's packet parser.

Parameters:
ADDR_WIDTH, 3, log2 of words per bank; each bank holds 2^ADDR_WIDTH 64-bit words.

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_areset  in  1  asynchronous reset, active low
i_rx_data_valid  in  8  byte-valid mask of current RX word; nonzero = word present
i_rx_data  in  64  RX word, byte 0 in [63:56]
i_rx_bad_frame  in  1  frame ended in error; qualifies the same cycle's word as last
i_rx_good_frame  in  1  frame ended OK; qualifies the same cycle's word as last
i_process_frame  in  1  pulse: hand the completed frame to dispatch side
o_dispatch_packet_available  out  1  a frame is held for the dispatch side
i_dispatch_packet_read_discard  in  1  pulse: dispatch side done; free its bank
o_dispatch_counter  out  ADDR_WIDTH  address of last word of held frame (word count - 1)
o_dispatch_data_valid  out  8  byte-valid mask of last word of held frame
o_dispatch_fifo_empty  out  1  all words of held frame have been read (1 when none held)
i_dispatch_fifo_rd_en  in  1  read next word
o_dispatch_fifo_rd_data  out  64  registered read data

Behaviour:
- Reset (i_areset low, async): both banks free, write pointer 0, read pointer 0. Outputs: available 0, counter 0, data_valid 0, fifo_empty 1, rd_data 0. Memory contents are not cleared.
- Write side: each edge with i_rx_data_valid != 0 writes i_rx_data to write bank[wr_ptr] and increments wr_ptr.
- If the word carries i_rx_good_frame: latch last address and its valid mask; the write bank becomes "complete".
- If the word carries i_rx_bad_frame: drop the frame and set wr_ptr to 0.
- Overflow: a word arriving when wr_ptr has already passed 2^ADDR_WIDTH-1 marks the frame overflowed. The frame is dropped at its end, whether good or bad.
- Complete bank + i_process_frame sampled:
  - If the read side is free, the banks swap at the next edge.
  - o_dispatch_packet_available rises on the edge after the one sampling i_process_frame; that is two edges after the process strobe is applied.
  - The counter and data_valid from the frame's last word are presented, the read pointer is set to 0, and fifo_empty goes to 0.
- Read side busy when i_process_frame arrives: the complete frame stays pending and is handed over automatically one cycle after the read side is freed.
- A complete frame with no process_frame is dropped when the next frame's first valid word arrives.
- i_process_frame with no complete frame is ignored.
- Read: i_dispatch_fifo_rd_en sampled with !fifo_empty → rd_data = bank[rd_ptr] after that edge (1-cycle latency), then rd_ptr++.
  - fifo_empty rises on the edge that reads address o_dispatch_counter.
  - rd_en while empty is ignored; rd_data holds.
- i_dispatch_packet_read_discard sampled: the next edge clears available, sets fifo_empty 1 and counter/data_valid to 0, and frees the bank. Discard with nothing available is ignored.
- Simultaneous rd_en and discard: discard wins.
- Writes never target the bank owned by the read side.

Optional Feature:
NTS_DISPATCHER_FRONTEND_DEBUG_COUNTERS_EN: when defined, adds outputs:
- o_dbg_frames_dispatched[31:0]: increments on each handover.
- o_dbg_frames_dropped[31:0]: increments on each bad, overflowed, unprocessed or superseded frame.
Both reset to 0 and saturate at all-ones. When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset → available 0, counter 0, data_valid 0, fifo_empty 1.
- Write 0x0102030405060708, 0x0000000220202020, then 0x0000000330303030 with good_frame, valid 0xFF each. Pulse process_frame → available 0 one edge later, 1 the next. Counter 2, data_valid 0xFF, fifo_empty 0.
- Hold rd_en for three cycles → rd_data shows the three words on successive edges; fifo_empty 1 with the third word. Then discard → available 0 next edge.
- Frame ending with bad_frame followed by process_frame → available stays 0; the next good frame dispatches normally from address 0.
- Frame of 9 words (ADDR_WIDTH=3) with good_frame + process → dropped, available stays 0.
- Second good frame processed while the first is still held → available stays 1 with the first frame's counter. After discard, the second frame appears with its own counter/data_valid (e.g. 1 word, valid 0x0F → counter 0, data_valid 0x0F).
